// File: rtl/cipher_mode_ctrl.sv
// Block-cipher chaining controller (ECB/CBC/CTR) in front of an external block engine.
// Optional macro CIPHER_MODE_CTR_EN builds CTR mode and its counter; otherwise mode 10 is ECB.
module cipher_mode_ctrl #(
  parameter int unsigned BLOCK_W    = 64,
  parameter int unsigned FIFO_DEPTH = 4   // power of two, >= 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_mode,
  input  logic               i_flag,
  input  logic [BLOCK_W-1:0] i_iv,
  input  logic               i_iv_en,
  input  logic [BLOCK_W-1:0] i_din,
  input  logic               i_din_en,
  output logic               o_din_rdy,
  output logic [BLOCK_W-1:0] o_dout,
  output logic               o_dout_en,
  output logic [BLOCK_W-1:0] o_eng_din,
  output logic               o_eng_din_en,
  output logic               o_eng_flag,
  input  logic [BLOCK_W-1:0] i_eng_dout,
  input  logic               i_eng_dout_en,
  output logic               o_busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ModeEcb = 2'b00;
  localparam logic [1:0] ModeCbc = 2'b01;
`ifdef CIPHER_MODE_CTR_EN
  localparam logic [1:0] ModeCtr = 2'b10;
`endif

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

  state_e              state_q, state_d;
  logic [BLOCK_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]       count_q, count_d;
  logic [1:0]          mode_q, mode_d, eff_mode;
  logic                flag_q, flag_d;
  logic [BLOCK_W-1:0]  din_q, din_d, chain_q, chain_d, head;
  logic [BLOCK_W-1:0]  dout_q, dout_d, eng_din_q, eng_din_d;
  logic                dout_en_q, dout_en_d, eng_din_en_q, eng_din_en_d, eng_flag_q, eng_flag_d;
  logic                push, pop;

  assign o_din_rdy    = (count_q != (PtrW+1)'(FIFO_DEPTH));
  assign push         = i_din_en && o_din_rdy;
  assign pop          = (state_q == StIssue);
  assign head         = mem_q[rd_ptr_q];
  assign o_busy       = (state_q != StIdle);
  assign o_dout       = dout_q;
  assign o_dout_en    = dout_en_q;
  assign o_eng_din    = eng_din_q;
  assign o_eng_din_en = eng_din_en_q;
  assign o_eng_flag   = eng_flag_q;

  // Reserved mode (and CTR when not built) collapses to ECB.
  always_comb begin
    eff_mode = ModeEcb;
    if (i_mode == ModeCbc) begin
      eff_mode = ModeCbc;
`ifdef CIPHER_MODE_CTR_EN
    end else if (i_mode == ModeCtr) begin
      eff_mode = ModeCtr;
`endif
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + (PtrW+1)'(push) - (PtrW+1)'(pop);
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    flag_d       = flag_q;
    din_d        = din_q;
    chain_d      = chain_q;
    dout_d       = dout_q;
    dout_en_d    = 1'b0;
    eng_din_d    = eng_din_q;
    eng_din_en_d = 1'b0;
    eng_flag_d   = eng_flag_q;
    unique case (state_q)
      StIdle: begin
        if (i_iv_en) begin
          chain_d = i_iv;
        end else if (count_q != '0) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        mode_d       = eff_mode;
        flag_d       = i_flag;
        din_d        = head;
        eng_din_d    = head;
        eng_flag_d   = i_flag;
        eng_din_en_d = 1'b1;
        if (eff_mode == ModeCbc && i_flag) begin
          eng_din_d = head ^ chain_q;
        end
`ifdef CIPHER_MODE_CTR_EN
        if (eff_mode == ModeCtr) begin
          eng_din_d  = chain_q;
          eng_flag_d = 1'b1;
        end
`endif
        state_d = StWait;
      end
      StWait: begin
        if (i_eng_dout_en) begin
          state_d   = StOut;
          dout_en_d = 1'b1;
          dout_d    = i_eng_dout;
          if (mode_q == ModeCbc) begin
            if (flag_q) begin
              chain_d = i_eng_dout;
            end else begin
              dout_d  = i_eng_dout ^ chain_q;
              chain_d = din_q;
            end
          end
`ifdef CIPHER_MODE_CTR_EN
          if (mode_q == ModeCtr) begin
            dout_d  = i_eng_dout ^ din_q;
            chain_d = chain_q + BLOCK_W'(1);
          end
`endif
        end
      end
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Storage is not reset; emptiness is defined by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_din;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mode_q       <= ModeEcb;
      flag_q       <= 1'b0;
      din_q        <= '0;
      chain_q      <= '0;
      dout_q       <= '0;
      dout_en_q    <= 1'b0;
      eng_din_q    <= '0;
      eng_din_en_q <= 1'b0;
      eng_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mode_q       <= mode_d;
      flag_q       <= flag_d;
      din_q        <= din_d;
      chain_q      <= chain_d;
      dout_q       <= dout_d;
      dout_en_q    <= dout_en_d;
      eng_din_q    <= eng_din_d;
      eng_din_en_q <= eng_din_en_d;
      eng_flag_q   <= eng_flag_d;
    end
  end

endmodule

// File: tb/tb_cipher_mode_ctrl.sv
// Self-checking bench for cipher_mode_ctrl: XOR engine stub, directed table, corner sequences,
// and randomized runs against a block-level chaining model.
module tb_cipher_mode_ctrl;

  localparam logic [63:0] K   = 64'hFFFF0000FFFF0000;
  localparam int          Lat = 16;
`ifdef CIPHER_MODE_CTR_EN
  localparam bit CtrOn = 1'b1;
`else
  localparam bit CtrOn = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [1:0]  i_mode = 2'b00;
  logic        i_flag = 1'b0;
  logic [63:0] i_iv = '0;
  logic        i_iv_en = 1'b0;
  logic [63:0] i_din = '0;
  logic        i_din_en = 1'b0;
  logic        o_din_rdy;
  logic [63:0] o_dout;
  logic        o_dout_en;
  logic [63:0] o_eng_din;
  logic        o_eng_din_en;
  logic        o_eng_flag;
  logic [63:0] i_eng_dout = '0;
  logic        i_eng_dout_en = 1'b0;
  logic        o_busy;

  always #5 i_clk = ~i_clk;

  cipher_mode_ctrl #(.BLOCK_W(64), .FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_flag(i_flag),
    .i_iv(i_iv), .i_iv_en(i_iv_en), .i_din(i_din), .i_din_en(i_din_en),
    .o_din_rdy(o_din_rdy), .o_dout(o_dout), .o_dout_en(o_dout_en),
    .o_eng_din(o_eng_din), .o_eng_din_en(o_eng_din_en), .o_eng_flag(o_eng_flag),
    .i_eng_dout(i_eng_dout), .i_eng_dout_en(i_eng_dout_en), .o_busy(o_busy)
  );

  // Captured DUT activity (written only by the negedge process below).
  logic [63:0] eng_in_q[$];
  logic        eng_flag_q[$];
  logic [63:0] out_q[$];
  logic        outprev_q[$];
  logic        lat_q[$];

  int          stub_cnt = 0;
  logic        stub_stale = 1'b0;
  logic        good_prev = 1'b0;
  logic [63:0] stub_hold = '0;
  int          inject_ack = 0;

  // Written only by the main initial block.
  logic        stall = 1'b0;
  int          inject_req = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] m_chain = '0;
  logic [63:0] exp_eng[$];
  logic        exp_flag[$];
  logic [63:0] exp_out[$];

  // Monitor first (sees last cycle's stub drive), then engine stub update.
  always @(negedge i_clk) begin
    if (i_rst) begin
      if (o_eng_din_en) begin
        eng_in_q.push_back(o_eng_din);
        eng_flag_q.push_back(o_eng_flag);
      end
      if (o_dout_en) begin
        out_q.push_back(o_dout);
        outprev_q.push_back(good_prev);
      end
      if (good_prev) lat_q.push_back(o_dout_en);
    end
    good_prev     = 1'b0;
    i_eng_dout_en = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) begin
        i_eng_dout_en = 1'b1;
        i_eng_dout    = stub_hold ^ K;
        good_prev     = !stub_stale;
      end
    end else if (inject_req != inject_ack) begin
      inject_ack    = inject_req;
      i_eng_dout_en = 1'b1;
      i_eng_dout    = stub_hold ^ K;
      good_prev     = 1'b1;
    end
    if (i_rst && o_eng_din_en) begin
      stub_hold  = o_eng_din;
      stub_stale = 1'b0;
      if (!stall) stub_cnt = Lat;
    end
    if (!i_rst) stub_stale = 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b0; i_din_en = 1'b0; i_iv_en = 1'b0;
    tick(); tick();
    chk("rst dout", o_dout, 64'h0);
    chk("rst dout_en", 64'(o_dout_en), 64'h0);
    chk("rst din_rdy", 64'(o_din_rdy), 64'h1);
    chk("rst busy", 64'(o_busy), 64'h0);
    chk("rst eng_din_en", 64'(o_eng_din_en), 64'h0);
    chk("rst eng_din", o_eng_din, 64'h0);
    chk("rst eng_flag", 64'(o_eng_flag), 64'h0);
    i_rst = 1'b1;
    tick();
    m_chain = '0;
  endtask

  task automatic load_iv(input logic [63:0] v);
    i_iv = v; i_iv_en = 1'b1;
    tick();
    i_iv_en = 1'b0;
  endtask

  task automatic push(input logic [63:0] d);
    bit ok;
    ok = 1'b0;
    i_din = d; i_din_en = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (o_din_rdy) ok = 1'b1;
      tick();
    end
    i_din_en = 1'b0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL push: got no ready want ready within 200 cycles");
    end
  endtask

  task automatic wait_outs(input int target, input string name);
    for (int c = 0; c < 4000 && out_q.size() < target; c++) tick();
    chk({name, " drain"}, 64'(out_q.size()), 64'(target));
  endtask

  // Spec-level chaining rules, one block at a time.
  task automatic model(input logic [1:0] m, input logic f, input logic [63:0] d);
    logic [63:0] ein, o;
    logic ef;
    ef = f;
    if (m == 2'b01) begin
      if (f) begin
        ein = d ^ m_chain; o = ein ^ K; m_chain = o;
      end else begin
        ein = d; o = (d ^ K) ^ m_chain; m_chain = d;
      end
    end else if (m == 2'b10 && CtrOn) begin
      ein = m_chain; ef = 1'b1; o = (m_chain ^ K) ^ d; m_chain = m_chain + 64'd1;
    end else begin
      ein = d; o = d ^ K;
    end
    exp_eng.push_back(ein); exp_flag.push_back(ef); exp_out.push_back(o);
  endtask

  task automatic cmp_model(input int be, input int bo, input string name);
    for (int i = 0; i < exp_out.size(); i++) begin
      chk({name, " eng_din"}, eng_in_q[be+i], exp_eng[i]);
      chk({name, " eng_flag"}, 64'(eng_flag_q[be+i]), 64'(exp_flag[i]));
      chk({name, " dout"}, out_q[bo+i], exp_out[i]);
    end
    exp_eng.delete(); exp_flag.delete(); exp_out.delete();
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        flag;
    logic [63:0] iv, d0, d1, e0, e1, o0, o1;
    logic        ef;
  } vec_t;

  initial begin
    vec_t  tbl[5];
    string names[5];
    int    be, bo, acc;
    logic [1:0]  rm;
    logic        rf;
    logic [63:0] rd;
    logic [63:0] pushed[$];

    names = '{"ecb_enc", "cbc_enc", "cbc_dec", "mode10", "mode11"};
    tbl[0] = '{2'b00, 1'b1, 64'h0, 64'h0123456789ABCDEF, 64'h0, 64'h0123456789ABCDEF, 64'h0,
               64'hFEDC45677654CDEF, K, 1'b1};
    tbl[1] = '{2'b01, 1'b1, 64'h1, 64'h0, 64'h0, 64'h1, 64'hFFFF0000FFFF0001,
               64'hFFFF0000FFFF0001, 64'h1, 1'b1};
    tbl[2] = '{2'b01, 1'b0, 64'h1, 64'h10, 64'h0, 64'h10, 64'h0,
               64'hFFFF0000FFFF0011, 64'hFFFF0000FFFF0010, 1'b0};
`ifdef CIPHER_MODE_CTR_EN
    tbl[3] = '{2'b10, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0,
               64'h0000FFFF0000FFFF, K, 1'b1};
`else
    tbl[3] = '{2'b10, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 64'h0, 64'h0, K, K, 1'b0};
`endif
    tbl[4] = '{2'b11, 1'b1, 64'h1, 64'h5, 64'h0, 64'h5, 64'h0, 64'hFFFF0000FFFF0005, K, 1'b1};

    for (int t = 0; t < 5; t++) begin
      do_reset();
      i_mode = tbl[t].mode; i_flag = tbl[t].flag;
      load_iv(tbl[t].iv);
      be = eng_in_q.size(); bo = out_q.size();
      push(tbl[t].d0);
      push(tbl[t].d1);
      wait_outs(bo + 2, names[t]);
      chk({names[t], " eng_din0"}, eng_in_q[be], tbl[t].e0);
      chk({names[t], " eng_din1"}, eng_in_q[be+1], tbl[t].e1);
      chk({names[t], " eng_flag0"}, 64'(eng_flag_q[be]), 64'(tbl[t].ef));
      chk({names[t], " eng_flag1"}, 64'(eng_flag_q[be+1]), 64'(tbl[t].ef));
      chk({names[t], " dout0"}, out_q[bo], tbl[t].o0);
      chk({names[t], " dout1"}, out_q[bo+1], tbl[t].o1);
      repeat (3) tick();
      chk({names[t], " dout hold"}, o_dout, tbl[t].o1);
      chk({names[t], " idle"}, 64'(o_busy), 64'h0);
    end

    // Stalled engine: FIFO fills, IV load during WAIT must be ignored (CBC decrypt exposes chain).
    do_reset();
    i_mode = 2'b01; i_flag = 1'b0;
    load_iv(64'h0123456789ABCDEF);
    m_chain = 64'h0123456789ABCDEF;
    stall = 1'b1;
    be = eng_in_q.size(); bo = out_q.size();
    acc = 0;
    pushed.delete();
    for (int c = 0; c < 12; c++) begin
      i_din = 64'h1000 + 64'(c); i_din_en = 1'b1;
      if (o_din_rdy) begin
        acc++;
        pushed.push_back(i_din);
      end
      tick();
    end
    i_din_en = 1'b0;
    chk("stall accepted", 64'(acc), 64'd5);
    chk("stall din_rdy", 64'(o_din_rdy), 64'h0);
    chk("stall busy", 64'(o_busy), 64'h1);
    i_iv = 64'hDEADBEEFCAFEF00D; i_iv_en = 1'b1;
    tick(); tick();
    i_iv_en = 1'b0;
    chk("stall no early out", 64'(out_q.size()), 64'(bo));
    stall = 1'b0;
    inject_req++;
    foreach (pushed[i]) model(2'b01, 1'b0, pushed[i]);
    wait_outs(bo + pushed.size(), "stall");
    cmp_model(be, bo, "stall");
    repeat (3) tick();

    // Reset during WAIT, stale engine done afterwards must not produce output.
    do_reset();
    i_mode = 2'b00; i_flag = 1'b1;
    be = eng_in_q.size(); bo = out_q.size();
    push(64'hA5A5A5A5A5A5A5A5);
    for (int c = 0; c < 20 && eng_in_q.size() == be; c++) tick();
    chk("midrst issued", 64'(eng_in_q.size()), 64'(be + 1));
    repeat (4) tick();
    chk("midrst busy before", 64'(o_busy), 64'h1);
    i_rst = 1'b0;
    tick();
    chk("midrst busy in rst", 64'(o_busy), 64'h0);
    chk("midrst eng_din in rst", o_eng_din, 64'h0);
    i_rst = 1'b1;
    repeat (30) tick();
    chk("midrst no out", 64'(out_q.size()), 64'(bo));
    chk("midrst idle", 64'(o_busy), 64'h0);
    chk("midrst din_rdy", 64'(o_din_rdy), 64'h1);
    chk("midrst dout_en", 64'(o_dout_en), 64'h0);
    be = eng_in_q.size(); bo = out_q.size();
    model(2'b00, 1'b1, 64'h0F0F0F0F0F0F0F0F);
    push(64'h0F0F0F0F0F0F0F0F);
    wait_outs(bo + 1, "midrst after");
    cmp_model(be, bo, "midrst after");
    repeat (3) tick();

    // Randomized runs: mode/flag fixed per run, chain carried across runs.
    do_reset();
    for (int r = 0; r < 14; r++) begin
      rm = 2'($urandom_range(0, 3));
      rf = 1'($urandom_range(0, 1));
      i_mode = rm; i_flag = rf;
      be = eng_in_q.size(); bo = out_q.size();
      if ($urandom_range(0, 1) == 1) begin
        rd = {$urandom, $urandom};
        load_iv(rd);
        m_chain = rd;
      end
      for (int k = 0, n = $urandom_range(1, 6); k < n; k++) begin
        rd = {$urandom, $urandom};
        if (k == 0 && $urandom_range(0, 1) == 1) begin
          // IV strobe held while a block is pending: the later IV must win.
          i_iv = {$urandom, $urandom}; i_iv_en = 1'b1;
          i_din = rd; i_din_en = 1'b1;
          tick();
          i_din_en = 1'b0;
          i_iv = {$urandom, $urandom};
          m_chain = i_iv;
          tick();
          i_iv_en = 1'b0;
        end else begin
          repeat ($urandom_range(0, 3)) tick();
          push(rd);
        end
        model(rm, rf, rd);
      end
      wait_outs(bo + exp_out.size(), "rand");
      cmp_model(be, bo, "rand");
      repeat (3) tick();
    end

    foreach (lat_q[i]) chk("latency dout_en after done", 64'(lat_q[i]), 64'h1);
    foreach (outprev_q[i]) chk("dout_en preceded by done", 64'(outprev_q[i]), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cipher_mode_ctrl.md
CIPHER_MODE_CTRL -- requirements
Module: cipher_mode_ctrl

Interface
REQ-001 Parameter BLOCK_W, default 64, is the cipher block width in bits (64 = DES/TDES, 128 = AES).
REQ-002 Parameter FIFO_DEPTH, default 4, is the input FIFO depth; it SHALL be a power of two and at least 2.
REQ-003 i_clk  in  1  the single clock; all logic is rising-edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-low.
REQ-005 i_mode  in  2  chaining mode: 00 ECB, 01 CBC, 10 CTR, 11 reserved (treated as ECB).
REQ-006 i_flag  in  1  direction: 1 encrypt, 0 decrypt.
REQ-007 i_iv / i_iv_en  in  BLOCK_W / 1  IV or initial counter value, with its load strobe.
REQ-008 i_din / i_din_en / o_din_rdy  in / in / out  BLOCK_W / 1 / 1  input block, valid and ready.
REQ-009 o_dout / o_dout_en  out  BLOCK_W / 1  result block and one-cycle valid pulse.
REQ-010 o_eng_din / o_eng_din_en / o_eng_flag  out  BLOCK_W / 1 / 1  block-engine input, start pulse and direction.
REQ-011 i_eng_dout / i_eng_dout_en  in  BLOCK_W / 1  block-engine result and done pulse.
REQ-012 o_busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-013 An input block SHALL be written to the FIFO on a clock edge where i_din_en and o_din_rdy are both high; o_din_rdy = !FIFO full (combinational).
REQ-014 FSM states: IDLE, ISSUE, WAIT, OUT.
REQ-015 IDLE -> ISSUE when the FIFO is non-empty and i_iv_en is low; ISSUE pops one block, latches i_mode and i_flag for that block, and pulses o_eng_din_en for exactly one cycle; ISSUE -> WAIT.
REQ-016 WAIT -> OUT on i_eng_dout_en; OUT pulses o_dout_en for one cycle, updates the chain register, then goes to IDLE.
REQ-017 o_eng_din SHALL be din (ECB), din ^ chain (CBC encrypt), din (CBC decrypt), or chain (CTR).
REQ-018 o_dout SHALL be eng (ECB), eng (CBC encrypt; chain <= eng), eng ^ chain (CBC decrypt; chain <= din), or eng ^ din (CTR; chain <= chain + 1 modulo 2^BLOCK_W).
REQ-019 o_eng_flag SHALL equal the latched i_flag, except in CTR mode, where it SHALL be 1.
REQ-020 i_iv_en SHALL load the chain register only in IDLE, and SHALL take priority over a pending FIFO block in the same cycle; it SHALL be ignored in any other state.
REQ-021 i_eng_dout_en outside WAIT SHALL be ignored.
REQ-022 Latency: o_dout_en SHALL assert exactly one cycle after the accepted i_eng_dout_en.
REQ-023 Simultaneous FIFO push and pop SHALL both take effect; the FIFO count is unchanged.
REQ-024 o_dout SHALL hold its value until the next o_dout_en.

Reset
REQ-025 While i_rst is low, the following SHALL be forced to the values below:
- state = IDLE
- FIFO empty, chain = 0
- o_dout = 0, o_dout_en = 0
- o_eng_din = 0, o_eng_din_en = 0, o_eng_flag = 0
- o_busy = 0
- o_din_rdy = 1
REQ-026 Reset asserted mid-operation SHALL discard the in-flight block; a late i_eng_dout_en after reset is released SHALL be ignored under REQ-021.

Configuration
REQ-027 Macro CIPHER_MODE_CTR_EN defined: CTR mode and the BLOCK_W-bit counter incrementer are present.
REQ-028 Macro CIPHER_MODE_CTR_EN undefined: no incrementer is built, and i_mode = 10 SHALL behave exactly as ECB.

Verification
Bench engine stub for all scenarios: result = input ^ K with K = 64'hFFFF0000FFFF0000, fixed latency 16 cycles; BLOCK_W = 64.
REQ-029 Reset -> o_dout = 0, o_dout_en = 0, o_din_rdy = 1, o_busy = 0, o_eng_din_en = 0.
REQ-030 ECB encrypt, din 64'h0123456789ABCDEF -> o_eng_din 64'h0123456789ABCDEF; o_dout 64'hFEDC45677654CDEF, one cycle after engine done.
REQ-031 CBC encrypt, IV 64'h1, din 0 then 0 -> engine inputs 64'h1 then 64'hFFFF0000FFFF0001; outputs 64'hFFFF0000FFFF0001 then 64'h1.
REQ-032 CTR (macro defined), IV 64'hFFFFFFFFFFFFFFFF, din 0 then 0 -> engine inputs all-ones then 0 (counter wraps); outputs 64'h0000FFFF0000FFFF then K; o_eng_flag = 1 even with i_flag = 0.
REQ-033 Engine stalled (never done), FIFO_DEPTH 4, din_en held high -> exactly 5 blocks accepted (1 in flight + 4 queued); o_din_rdy low afterwards; i_iv_en is ignored and the chain is unchanged.
REQ-034 Reset pulsed during WAIT, then the stale engine done arrives -> no o_dout_en, FIFO empty, state IDLE.
